merge_3: RTL and testbench

- Three-way result merge: the reverse direction of the opcode-steered three-way request split in the execute stage.
- Collects completed results from the three execution lanes (lane 1 branch/jump, lane 2 load/store, lane 3 ALU/NOP) and forwards one result at a time to the single writeback consumer.
- Uses four-phase req/ack handshakes on every side, sampled on one clock.
- Arbitrates simultaneous lane requests and holds the selected result in a register until writeback has fully acknowledged it.

---
 rtl/merge_3.sv | 156 +++++++++++++++
 tb/tb_merge_3.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_3.sv
// merge_3: three-way result merge from the execution lanes into writeback.
// Lane 1 = branch/jump, lane 2 = load/store, lane 3 = ALU/NOP.
// Four-phase req/ack handshakes on every side, all sampled on clk.
// Optional feature macro: MERGE3_RR_EN selects round-robin arbitration;
// when it is undefined, arbitration is fixed priority 1 > 2 > 3.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer held; grant a requesting lane when ack_in is low
// FWD   | result held in data_out, req_out high, waiting for ack_in
// ACKU  | writeback acked; ack_out_k high until lane req and ack_in fall
module merge_3 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in_1,
  input  logic              req_in_2,
  input  logic              req_in_3,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  output logic              ack_out_1,
  output logic              ack_out_2,
  output logic              ack_out_3,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        src_out,
  input  logic              ack_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ACKU = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        ack_q;
  logic [2:0]        req_vec;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] gnt_data;
  logic              sel_req;

  assign ack_out_1 = ack_q[0];
  assign ack_out_2 = ack_q[1];
  assign ack_out_3 = ack_q[2];

  // A lane still holding its acknowledge is not eligible for a new grant.
  assign req_vec = {req_in_3 & ~ack_q[2], req_in_2 & ~ack_q[1], req_in_1 & ~ack_q[0]};

`ifdef MERGE3_RR_EN
  logic [1:0] ptr;

  // Round-robin pick: search starts at ptr and wraps 3 -> 1.
  always_comb begin
    gnt = 2'd0;
    case (ptr)
      2'd2:    gnt = req_vec[1] ? 2'd2 : req_vec[2] ? 2'd3 : req_vec[0] ? 2'd1 : 2'd0;
      2'd3:    gnt = req_vec[2] ? 2'd3 : req_vec[0] ? 2'd1 : req_vec[1] ? 2'd2 : 2'd0;
      default: gnt = req_vec[0] ? 2'd1 : req_vec[1] ? 2'd2 : req_vec[2] ? 2'd3 : 2'd0;
    endcase
  end

  // Advance the pointer to the lane after the one just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd1;
    end else if (state == IDLE && !ack_in && gnt != 2'd0) begin
      case (gnt)
        2'd1:    ptr <= 2'd2;
        2'd2:    ptr <= 2'd3;
        default: ptr <= 2'd1;
      endcase
    end
  end
`else
  // Fixed priority pick: lane 1 > lane 2 > lane 3.
  always_comb begin
    gnt = 2'd0;
    if (req_vec[0])      gnt = 2'd1;
    else if (req_vec[1]) gnt = 2'd2;
    else if (req_vec[2]) gnt = 2'd3;
  end
`endif

  // Result of the lane being granted this cycle.
  always_comb begin
    gnt_data = '0;
    case (gnt)
      2'd1:    gnt_data = data_in_1;
      2'd2:    gnt_data = data_in_2;
      2'd3:    gnt_data = data_in_3;
      default: gnt_data = '0;
    endcase
  end

  // Request level of the lane currently holding the transfer.
  always_comb begin
    sel_req = 1'b0;
    case (src_out)
      2'd1:    sel_req = req_in_1;
      2'd2:    sel_req = req_in_2;
      2'd3:    sel_req = req_in_3;
      default: sel_req = 1'b0;
    endcase
  end

  // Handshake sequencer; src_out doubles as the index of the held lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      ack_q    <= 3'b000;
      data_out <= '0;
      src_out  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!ack_in && gnt != 2'd0) begin
            data_out <= gnt_data;
            src_out  <= gnt;
            req_out  <= 1'b1;
            state    <= FWD;
          end
        end
        FWD: begin
          if (ack_in) begin
            req_out <= 1'b0;
            case (src_out)
              2'd1:    ack_q <= 3'b001;
              2'd2:    ack_q <= 3'b010;
              2'd3:    ack_q <= 3'b100;
              default: ack_q <= 3'b000;
            endcase
            state <= ACKU;
          end
        end
        ACKU: begin
          if (!sel_req && !ack_in) begin
            ack_q   <= 3'b000;
            src_out <= 2'd0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
          ack_q   <= 3'b000;
          src_out <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_3.sv
// Bench for merge_3: transaction-level model checked every cycle plus
// directed scenarios with literal expectations. Honors MERGE3_RR_EN.
module tb_merge_3;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_in_1, req_in_2, req_in_3;
  logic [DATA_W-1:0] data_in_1, data_in_2, data_in_3;
  logic              ack_out_1, ack_out_2, ack_out_3;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        src_out;
  logic              ack_in;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  merge_3 #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_in_1(req_in_1), .req_in_2(req_in_2), .req_in_3(req_in_3),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .ack_out_1(ack_out_1), .ack_out_2(ack_out_2), .ack_out_3(ack_out_3),
    .req_out(req_out), .data_out(data_out), .src_out(src_out), .ack_in(ack_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- transaction model ----------------
  // m_lane: lane whose result is held (0 = none); m_dack: writeback has acked it.
  int          m_lane;
  bit          m_dack;
  logic [31:0] m_data;
  int          m_ptr;

  function automatic bit lane_req(input int k);
    case (k)
      1: return req_in_1;
      2: return req_in_2;
      3: return req_in_3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input int k);
    case (k)
      1: return data_in_1;
      2: return data_in_2;
      3: return data_in_3;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_pick(input int ptr);
    int k;
    for (int i = 0; i < 3; i++) begin
      k = ((ptr - 1 + i) % 3) + 1;
      if (lane_req(k)) return k;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lane <= 0;
      m_dack <= 1'b0;
      m_data <= 32'h0;
      m_ptr  <= 1;
    end else if (m_lane == 0) begin
      if (!ack_in && model_pick(m_ptr) != 0) begin
        m_lane <= model_pick(m_ptr);
        m_dack <= 1'b0;
        m_data <= lane_data(model_pick(m_ptr));
`ifdef MERGE3_RR_EN
        m_ptr  <= (model_pick(m_ptr) % 3) + 1;
`endif
      end
    end else if (!m_dack) begin
      if (ack_in) m_dack <= 1'b1;
    end else if (!lane_req(m_lane) && !ack_in) begin
      m_lane <= 0;
      m_dack <= 1'b0;
    end
  end

  function automatic logic [63:0] exp_vec();
    return {26'b0, (m_lane != 0) && !m_dack, (m_lane == 3) && m_dack,
            (m_lane == 2) && m_dack, (m_lane == 1) && m_dack, 2'(m_lane), m_data};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {26'b0, req_out, ack_out_3, ack_out_2, ack_out_1, src_out, data_out};
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) chk("model_outputs", dut_vec(), exp_vec());

  // Grant order log: src_out captured at each rising req_out.
  logic prev_req = 1'b0;
  int   order_q[$];
  always @(negedge clk) begin
    if (req_out && !prev_req) order_q.push_back(int'(src_out));
    prev_req <= req_out;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_in_1 = 0; req_in_2 = 0; req_in_3 = 0; ack_in = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Auto-responding lanes and writeback; each lane issues left[k] requests.
  task automatic run_auto(input int l1, input int l2, input int l3, input int n_expect);
    int left[1:3];
    int cyc;
    bit done;
    left[1] = l1; left[2] = l2; left[3] = l3;
    cyc = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      ack_in = req_out;
      if (req_in_1 && ack_out_1) req_in_1 = 0;
      else if (!req_in_1 && !ack_out_1 && left[1] > 0) begin
        data_in_1 = 32'hA100_0000 + 32'(left[1]); req_in_1 = 1; left[1]--;
      end
      if (req_in_2 && ack_out_2) req_in_2 = 0;
      else if (!req_in_2 && !ack_out_2 && left[2] > 0) begin
        data_in_2 = 32'hA200_0000 + 32'(left[2]); req_in_2 = 1; left[2]--;
      end
      if (req_in_3 && ack_out_3) req_in_3 = 0;
      else if (!req_in_3 && !ack_out_3 && left[3] > 0) begin
        data_in_3 = 32'hA300_0000 + 32'(left[3]); req_in_3 = 1; left[3]--;
      end
      cyc++;
      if (order_q.size() >= n_expect && !req_out && src_out == 2'd0 &&
          !req_in_1 && !req_in_2 && !req_in_3 &&
          left[1] == 0 && left[2] == 0 && left[3] == 0) done = 1;
      else if (cyc >= 300) begin
        n_total++;
        $display("FAIL auto_timeout: got %0d grants expected %0d", order_q.size(), n_expect);
        done = 1;
      end
    end
    ack_in = 0;
  endtask

  task automatic chk_order(input int exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++)
      chk("grant_order", 64'((i < order_q.size()) ? order_q[i] : 0), 64'(exp_q[i]));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int exp_q[$];
    rst = 1'b1;
    req_in_1 = 0; req_in_2 = 0; req_in_3 = 0; ack_in = 0;
    data_in_1 = 0; data_in_2 = 0; data_in_3 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", dut_vec(), 64'h0);
    rst = 1'b0;

    // Single lane 3 transfer.
    req_in_3 = 1; data_in_3 = 32'hDEADBEEF;
    @(negedge clk);
    chk("l3_data", 64'(data_out), 64'hDEADBEEF);
    chk("l3_src", 64'(src_out), 64'd3);
    chk("l3_req", 64'(req_out), 64'd1);
    ack_in = 1;
    @(negedge clk);
    chk("l3_req_fall", 64'(req_out), 64'd0);
    chk("l3_ack", 64'(ack_out_3), 64'd1);
    req_in_3 = 0; ack_in = 0;
    @(negedge clk);
    chk("l3_ack_fall", 64'(ack_out_3), 64'd0);
    chk("l3_src_clr", 64'(src_out), 64'd0);
    chk("l3_data_keep", 64'(data_out), 64'hDEADBEEF);

    // ack_in held high in IDLE blocks the grant.
    ack_in = 1; req_in_1 = 1; data_in_1 = 32'h11111111;
    repeat (3) @(negedge clk);
    chk("ackhi_no_grant", 64'(req_out), 64'd0);
    ack_in = 0;
    @(negedge clk);
    chk("ackhi_grant_req", 64'(req_out), 64'd1);
    chk("ackhi_grant_src", 64'(src_out), 64'd1);
    ack_in = 1;
    @(negedge clk);
    chk("ackhi_ack1", 64'(ack_out_1), 64'd1);
    req_in_1 = 0; ack_in = 0;
    @(negedge clk);
    chk("ackhi_idle", 64'(src_out), 64'd0);

    // Slow lane 2 keeps the FSM in ACKU; lane 1 must wait.
    req_in_2 = 1; data_in_2 = 32'h22222222;
    @(negedge clk);
    chk("slow_src", 64'(src_out), 64'd2);
    ack_in = 1;
    @(negedge clk);
    chk("slow_ack2", 64'(ack_out_2), 64'd1);
    ack_in = 0; req_in_1 = 1; data_in_1 = 32'h11110001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("slow_hold_ack2", 64'(ack_out_2), 64'd1);
      chk("slow_no_grant1", 64'(req_out), 64'd0);
    end
    req_in_2 = 0;
    @(negedge clk);
    chk("slow_ack2_fall", 64'(ack_out_2), 64'd0);
    chk("slow_src_clr", 64'(src_out), 64'd0);
    @(negedge clk);
    chk("slow_grant1_src", 64'(src_out), 64'd1);
    chk("slow_grant1_data", 64'(data_out), 64'h11110001);
    ack_in = 1;
    @(negedge clk);
    req_in_1 = 0; ack_in = 0;
    @(negedge clk);
    chk("slow_done", 64'(src_out), 64'd0);

    // Reset in the middle of FWD with lane 2 still requesting.
    req_in_2 = 1; data_in_2 = 32'h22220002;
    @(negedge clk);
    chk("rst_pre_src", 64'(src_out), 64'd2);
    #2 rst = 1'b1;
    #1 chk("rst_async_zero", dut_vec(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_regrant_src", 64'(src_out), 64'd2);
    chk("rst_regrant_req", 64'(req_out), 64'd1);
    chk("rst_regrant_data", 64'(data_out), 64'h22220002);
    ack_in = 1;
    @(negedge clk);
    chk("rst_ack2", 64'(ack_out_2), 64'd1);
    req_in_2 = 0; ack_in = 0;
    @(negedge clk);

    // Simultaneous requests, one each.
    do_reset();
    order_q.delete();
    run_auto(1, 1, 1, 3);
    exp_q = '{1, 2, 3};
    chk_order(exp_q);

    // Simultaneous requests, lanes re-request right after each handshake.
    do_reset();
    order_q.delete();
    run_auto(2, 2, 2, 6);
`ifdef MERGE3_RR_EN
    exp_q = '{1, 2, 3, 1, 2, 3};
`else
    exp_q = '{1, 1, 2, 2, 3, 3};
`endif
    chk_order(exp_q);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
